// File: rtl/fifo_ser_tx_pkg.sv
// Shared types for the serial byte-link transmitter.
package ser_tx_pkg;

  typedef enum logic [2:0] {IDLE, RD, LATCH, SHIFT, PAR, GAP} ser_tx_state_t;

  localparam int SER_DATA_W_DEF = 8;

endpackage

// File: rtl/fifo_ser_tx_if.sv
// FIFO-read plus serial-link signal bundle for fifo_ser_tx.
// master: the transmitter side; slave: FIFO and receiver side.
import ser_tx_pkg::*;

interface fifo_ser_tx_if #(parameter int DATA_W = SER_DATA_W_DEF);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_rd;
  logic              serial_data;
  logic              data_ena;
  logic              busy;
  logic              byte_done;

  modport master (
    input  fifo_empty, fifo_data,
    output fifo_rd, serial_data, data_ena, busy, byte_done
  );

  modport slave (
    output fifo_empty, fifo_data,
    input  fifo_rd, serial_data, data_ena, busy, byte_done
  );
endinterface

// File: rtl/fifo_ser_tx.sv
// Parallel-to-serial transmitter: pops one word from a non-showahead FIFO and
// shifts it out LSB first with data_ena marking each frame bit.
// Optional build macro: SER_TX_PARITY_EN appends an even-parity bit per frame.
import ser_tx_pkg::*;

module fifo_ser_tx #(
  parameter int DATA_W     = SER_DATA_W_DEF,
  parameter int GAP_CYCLES = 0
) (
  input  logic            clk_50,
  input  logic            reset_n,
  fifo_ser_tx_if.master   tx
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [7:0] GAP_LOAD = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  ser_tx_state_t     state, state_nxt;
  logic [DATA_W-1:0] sreg, sreg_nxt;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [7:0]        gap_cnt, gap_cnt_nxt;
`ifdef SER_TX_PARITY_EN
  logic              parity, parity_nxt;
`endif

  // Where a frame goes once its last bit is out: forced gap, or straight to
  // the next pop when the FIFO still has data.
  ser_tx_state_t post_state, resume_state;

  // State register, shift register and counters.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
`ifdef SER_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      sreg    <= sreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      gap_cnt <= gap_cnt_nxt;
`ifdef SER_TX_PARITY_EN
      parity  <= parity_nxt;
`endif
    end
  end

  // Next-state and datapath updates; outputs decode from registered state only.
  always_comb begin
    state_nxt      = state;
    sreg_nxt       = sreg;
    bit_cnt_nxt    = bit_cnt;
    gap_cnt_nxt    = gap_cnt;
`ifdef SER_TX_PARITY_EN
    parity_nxt     = parity;
`endif
    tx.fifo_rd     = 1'b0;
    tx.serial_data = 1'b0;
    tx.data_ena    = 1'b0;
    tx.byte_done   = 1'b0;
    tx.busy        = (state != IDLE);

    resume_state = tx.fifo_empty ? IDLE : RD;
    post_state   = (GAP_CYCLES > 0) ? GAP : resume_state;

    case (state)
      IDLE: begin
        if (!tx.fifo_empty) state_nxt = RD;
      end
      RD: begin
        tx.fifo_rd = 1'b1;
        state_nxt  = LATCH;
      end
      LATCH: begin
        // FIFO data is valid now, one cycle after the pop strobe.
        sreg_nxt    = tx.fifo_data;
        bit_cnt_nxt = '0;
`ifdef SER_TX_PARITY_EN
        parity_nxt  = ^tx.fifo_data;
`endif
        state_nxt   = SHIFT;
      end
      SHIFT: begin
        tx.data_ena    = 1'b1;
        tx.serial_data = sreg[0];
        sreg_nxt       = sreg >> 1;
        if (bit_cnt == LAST_BIT) begin
`ifdef SER_TX_PARITY_EN
          state_nxt    = PAR;
`else
          tx.byte_done = 1'b1;
          state_nxt    = post_state;
          gap_cnt_nxt  = GAP_LOAD;
`endif
        end else begin
          bit_cnt_nxt = bit_cnt + 1'b1;
        end
      end
`ifdef SER_TX_PARITY_EN
      PAR: begin
        tx.data_ena    = 1'b1;
        tx.serial_data = parity;
        tx.byte_done   = 1'b1;
        state_nxt      = post_state;
        gap_cnt_nxt    = GAP_LOAD;
      end
`endif
      GAP: begin
        if (gap_cnt == 8'd0) state_nxt = resume_state;
        else                 gap_cnt_nxt = gap_cnt - 8'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_ser_tx.sv
// Self-checking bench for fifo_ser_tx: directed vector table, multi-cycle
// corner sequences (back-to-back, gap, mid-frame reset) and a randomized
// run scored against a byte-queue model of the link.
`timescale 1ns/1ps
module tb_fifo_ser_tx;

`ifdef SER_TX_PARITY_EN
  localparam int FW = 9;
`else
  localparam int FW = 8;
`endif

  logic clk_50 = 1'b0;
  logic reset_n = 1'b0;
  always #10 clk_50 = ~clk_50;

  fifo_ser_tx_if #(.DATA_W(8)) bus0 ();
  fifo_ser_tx_if #(.DATA_W(8)) bus1 ();

  fifo_ser_tx #(.DATA_W(8), .GAP_CYCLES(0)) u_dut0 (.clk_50(clk_50), .reset_n(reset_n), .tx(bus0));
  fifo_ser_tx #(.DATA_W(8), .GAP_CYCLES(3)) u_dut1 (.clk_50(clk_50), .reset_n(reset_n), .tx(bus1));

  // Non-showahead FIFO models: data appears the cycle after the pop strobe.
  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  logic [7:0] wr0 = 8'd0, rd0 = 8'd0, wr1 = 8'd0, rd1 = 8'd0;
  assign bus0.fifo_empty = (wr0 == rd0);
  assign bus1.fifo_empty = (wr1 == rd1);

  always @(posedge clk_50) begin
    if (bus0.fifo_rd) begin bus0.fifo_data <= mem0[rd0]; rd0 <= rd0 + 8'd1; end
    if (bus1.fifo_rd) begin bus1.fifo_data <= mem1[rd1]; rd1 <= rd1 + 8'd1; end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int sel, input logic [7:0] d);
    if (sel == 0) begin mem0[wr0] = d; wr0 = wr0 + 8'd1; end
    else          begin mem1[wr1] = d; wr1 = wr1 + 8'd1; end
  endtask

  // {fifo_rd, serial_data, data_ena, busy, byte_done}
  function automatic logic [4:0] outs(input int sel);
    if (sel == 0) return {bus0.fifo_rd, bus0.serial_data, bus0.data_ena, bus0.busy, bus0.byte_done};
    return {bus1.fifo_rd, bus1.serial_data, bus1.data_ena, bus1.busy, bus1.byte_done};
  endfunction

  // Capture buffer, sampled on the falling edge.
  bit rd_t [128], ser_t [128], ena_t [128], busy_t [128], done_t [128];
  int cap_n;

  task automatic capture(input int sel, input int n);
    logic [4:0] o;
    cap_n = n;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_50);
      o = outs(sel);
      {rd_t[i], ser_t[i], ena_t[i], busy_t[i], done_t[i]} = o;
    end
  endtask

  function automatic int burst_start(input int k);
    int seen = 0;
    for (int i = 0; i < cap_n; i++)
      if (ena_t[i] && (i == 0 || !ena_t[i-1])) begin
        if (seen == k) return i;
        seen++;
      end
    return -1;
  endfunction

  function automatic int burst_len(input int s);
    int n = 0;
    if (s < 0) return 0;
    for (int i = s; i < cap_n && ena_t[i]; i++) n++;
    return n;
  endfunction

  function automatic int count_in(input int a, input int b, input int which);
    int n = 0;
    for (int i = a; i < b && i < cap_n; i++) begin
      if (i < 0) continue;
      case (which)
        0: n += int'(rd_t[i]);
        1: n += int'(ena_t[i]);
        2: n += int'(busy_t[i]);
        3: n += int'(done_t[i]);
        default: n += int'(ser_t[i] && !ena_t[i]);
      endcase
    end
    return n;
  endfunction

  // Bits in transmission order, bit j = j-th transmitted bit.
  function automatic logic [8:0] burst_bits(input int s);
    logic [8:0] b = '0;
    if (s < 0) return b;
    for (int j = 0; j < FW; j++) if (s + j < cap_n) b[j] = ser_t[s + j];
    return b;
  endfunction

  // Received byte as a looped-back LSB-first shift register would hold it.
  function automatic int rx_byte(input int s);
    logic [8:0] b = burst_bits(s);
    return int'(b[7:0]);
  endfunction

  // Wire order as listed left-to-right (first bit at MSB).
  function automatic int wire_order(input int s);
    logic [8:0] b = burst_bits(s);
    logic [7:0] w;
    for (int j = 0; j < 8; j++) w[7-j] = b[j];
    return int'(w);
  endfunction

  typedef struct {
    logic [7:0] din;
    logic [7:0] order;  // expected wire bits, first transmitted at MSB
    logic       par;    // expected parity bit
  } vec_t;

  vec_t vt [6];

  initial begin
    int s0, s1, seen;
    logic [4:0] o;
    logic [8:0] bits;

    vt[0] = '{8'hA5, 8'b10100101, 1'b0};
    vt[1] = '{8'h01, 8'b10000000, 1'b1};
    vt[2] = '{8'h80, 8'b00000001, 1'b1};
    vt[3] = '{8'h07, 8'b11100000, 1'b1};
    vt[4] = '{8'h03, 8'b11000000, 1'b0};
    vt[5] = '{8'hFE, 8'b01111111, 1'b1};

    // Reset held with a non-empty FIFO: everything stays low.
    push(0, 8'h5A);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_50);
      seen += int'(outs(0) != 5'd0) + int'(outs(1) != 5'd0);
    end
    chk("reset_outs_zero", seen, 0);
    @(negedge clk_50);
    reset_n = 1'b1;
    #1;
    chk("first_cycle_after_reset", int'(outs(0)), 0);
    capture(0, 16);
    s0 = burst_start(0);
    chk("post_reset_latency", s0, 2);
    chk("post_reset_rx", rx_byte(s0), 8'h5A);

    // Table of single frames on the no-gap instance.
    foreach (vt[k]) begin
      push(0, vt[k].din);
      capture(0, 16);
      s0 = burst_start(0);
      bits = burst_bits(s0);
      chk($sformatf("v%0d_rd_pulses", k), count_in(0, cap_n, 0), 1);
      chk($sformatf("v%0d_rd_at_0", k), int'(rd_t[0]), 1);
      chk($sformatf("v%0d_first_bit", k), s0, 2);
      chk($sformatf("v%0d_ena_len", k), burst_len(s0), FW);
      chk($sformatf("v%0d_wire_order", k), wire_order(s0), int'(vt[k].order));
      chk($sformatf("v%0d_rx", k), rx_byte(s0), int'(vt[k].din));
`ifdef SER_TX_PARITY_EN
      chk($sformatf("v%0d_parity", k), int'(bits[8]), int'(vt[k].par));
`endif
      chk($sformatf("v%0d_done_cnt", k), count_in(0, cap_n, 3), 1);
      chk($sformatf("v%0d_done_pos", k), int'(done_t[s0 + FW - 1]), 1);
      chk($sformatf("v%0d_busy_span", k), count_in(0, cap_n, 2), FW + 2);
      chk($sformatf("v%0d_ser_idle_zero", k), count_in(0, cap_n, 4), 0);
    end

    // Back-to-back, no gap: 2 idle cycles between bursts.
    push(0, 8'h01);
    push(0, 8'h80);
    capture(0, 40);
    s0 = burst_start(0);
    s1 = burst_start(1);
    chk("b2b_rd_pulses", count_in(0, cap_n, 0), 2);
    chk("b2b_gap", s1 - (s0 + burst_len(s0)), 2);
    chk("b2b_rx0", rx_byte(s0), 8'h01);
    chk("b2b_rx1", rx_byte(s1), 8'h80);

    // GAP_CYCLES=3 instance: 5 idle cycles, no pop inside the forced gap.
    push(1, 8'h3C);
    push(1, 8'hC3);
    capture(1, 48);
    s0 = burst_start(0);
    s1 = burst_start(1);
    chk("gap3_gap", s1 - (s0 + burst_len(s0)), 5);
    chk("gap3_rd_in_gap", count_in(s0 + FW, s0 + FW + 3, 0), 0);
    chk("gap3_rd_pulses", count_in(0, cap_n, 0), 2);
    chk("gap3_rx0", rx_byte(s0), 8'h3C);
    chk("gap3_rx1", rx_byte(s1), 8'hC3);
    chk("gap3_ser_idle_zero", count_in(0, cap_n, 4), 0);

    // Reset after 4 bits of 8'hFF: outputs drop at once, byte not re-sent.
    push(0, 8'hFF);
    seen = 0;
    for (int i = 0; i < 20 && seen < 4; i++) begin
      @(negedge clk_50);
      seen += int'(bus0.data_ena);
    end
    chk("midrst_reached_4_bits", seen, 4);
    #3 reset_n = 1'b0;
    #1;
    o = outs(0);
    chk("midrst_outs_zero", int'(o), 0);
    @(negedge clk_50);
    reset_n = 1'b1;
    capture(0, 20);
    chk("midrst_no_ena", count_in(0, cap_n, 1), 0);
    chk("midrst_no_rd", count_in(0, cap_n, 0), 0);
    chk("midrst_idle", count_in(0, cap_n, 2), 0);

    // Randomized traffic on both instances against a byte-queue model.
    for (int sel = 0; sel < 2; sel++) begin
      logic [7:0] expq [$];
      logic [8:0] acc;
      logic [7:0] exp_b;
      int nb, last_end, frames, pushes, bad_idle, bad_rd, min_gap;
      logic [4:0] r;
      nb = 0; last_end = -1; frames = 0; pushes = 0; bad_idle = 0; bad_rd = 0;
      acc = '0;
      min_gap = (sel == 0) ? 2 : 5;
      for (int c = 0; c < 3000; c++) begin
        @(negedge clk_50);
        r = outs(sel);
        // r = {rd, ser, ena, busy, done}
        if (r[2]) begin
          if (nb == 0 && last_end >= 0 && (c - last_end - 1) < min_gap) begin
            chk("rnd_gap_min", c - last_end - 1, min_gap);
          end
          acc[nb] = r[3];
          if (r[0] != (nb == FW - 1)) begin
            chk("rnd_done_pos", int'(r[0]), int'(nb == FW - 1));
          end
          nb++;
          if (nb == FW) begin
            frames++;
            if (expq.size() == 0) chk("rnd_unexpected_frame", int'(acc[7:0]), -1);
            else begin
              exp_b = expq.pop_front();
              chk("rnd_rx", int'(acc[7:0]), int'(exp_b));
`ifdef SER_TX_PARITY_EN
              chk("rnd_parity", int'(acc[8]), int'(^exp_b));
`endif
            end
            nb = 0;
            last_end = c;
          end
        end else begin
          bad_idle += int'(r[3] || r[0]);
        end
        if (r[4] && (r[2] || !r[1])) bad_rd++;
        if (c < 2200 && pushes < 60 && $urandom_range(0, 9) == 0) begin
          exp_b = 8'($urandom);
          push(sel, exp_b);
          expq.push_back(exp_b);
          pushes++;
        end
      end
      chk($sformatf("rnd%0d_frames", sel), frames, pushes);
      chk($sformatf("rnd%0d_queue_drained", sel), expq.size(), 0);
      chk($sformatf("rnd%0d_idle_outputs", sel), bad_idle, 0);
      chk($sformatf("rnd%0d_rd_placement", sel), bad_rd, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
